l2_tag_ctrl: RTL and testbench
==============================

L2_TAG_CTRL -- requirements
Module: l2_tag_ctrl

Interface
REQ-001 SHALL have parameter WAYS, 8, associativity; power of two, 2..16.
REQ-002 SHALL have parameter INDEX_W, 6, set index width; SETS = 2**INDEX_W.
REQ-003 SHALL have parameter TAG_W, 12, tag width.
REQ-004 SHALL derive CNT_W = log2(WAYS), the width of the way number and the LRU age field.
REQ-005 SHALL run from one clock; reset is asynchronous and active-low.
REQ-006 Port: clk  in  1  rising-edge clock.
REQ-007 Port: rst_n  in  1  asynchronous active-low reset.
REQ-008 Port: req_valid  in  1  request present.
REQ-009 Port: req_ready  out  1  controller accepts a request this cycle.
REQ-010 Port: req_op  in  2  00 read, 01 write, 10 invalidate, 11 treated as read.
REQ-011 Port: req_index / req_tag  in  INDEX_W / TAG_W  lookup address.
REQ-012 Port: wb_valid / wb_ready  out / in  1 / 1  dirty-victim writeback handshake.
REQ-013 Port: wb_index / wb_tag  out  INDEX_W / TAG_W  writeback line address.
REQ-014 Port: rsp_valid  out  1  one-cycle response pulse.
REQ-015 Port: rsp_hit / rsp_way  out  1 / CNT_W  hit flag; way hit or way filled.

Function
REQ-016 SHALL store valid, dirty, TAG_W tag and CNT_W age for each of SETS x WAYS entries.
REQ-017 SHALL use the FSM states IDLE, LOOKUP, WB, UPDATE, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL capture op, index and tag on req_valid&&req_ready and move IDLE->LOOKUP.
REQ-019 LOOKUP SHALL compare the tag against all valid ways in one cycle; hit = exactly one valid way with a matching tag.
REQ-020 On a read/write miss, the victim SHALL be the lowest-index invalid way; if no way is invalid, the way with the largest age, lowest index on a tie.
REQ-021 On a miss whose victim is valid and dirty, or an invalidate hit on a dirty line, the FSM SHALL go LOOKUP->WB; otherwise LOOKUP->UPDATE.
REQ-022 WB SHALL hold wb_valid=1 with the victim's wb_index and wb_tag stable until wb_ready=1, then go to UPDATE; wb_valid SHALL be 0 in all other states.
REQ-023 UPDATE for a read/write hit: set dirty if op=write; apply LRU to the hit way.
REQ-024 UPDATE for a read/write miss: write the tag, valid=1, dirty=(op==write); apply LRU to the victim way.
REQ-025 UPDATE for an invalidate hit: clear valid and dirty and leave the ages unchanged; an invalidate miss changes nothing.
REQ-026 LRU on way w with old age A (A = WAYS-1 if w was invalid):
- every other valid way with age < A increments its age, saturating at WAYS-1;
- the age of w becomes 0.
REQ-027 RESP SHALL pulse rsp_valid for exactly one cycle, then return to IDLE.
REQ-028 rsp_hit and rsp_way SHALL be valid only while rsp_valid=1.
- rsp_way = hit way on a hit, victim way on a read/write miss.
- rsp_way = 0 on an invalidate miss.
REQ-029 Latency SHALL be as follows, with the accept cycle as 0:
- rsp_valid at cycle 3 when there is no writeback;
- rsp_valid 2 cycles after the cycle in which wb_valid&&wb_ready.
REQ-030 SHALL process one request at a time; a req_valid arriving outside IDLE is held off by req_ready=0.

Reset
REQ-031 On rst_n=0, immediately and at any point mid-operation:
- FSM SHALL go to IDLE;
- req_ready=0, wb_valid=0, rsp_valid=0, rsp_hit=0, rsp_way=0, wb_index=0, wb_tag=0;
- all valid, dirty and age bits SHALL be cleared.
REQ-032 req_ready SHALL rise in the first clock after rst_n deasserts; any writeback in flight is abandoned and not reissued.

Verification (WAYS=4, INDEX_W=2, TAG_W=8)
REQ-033 Cold read idx 1 tag 0x11 -> rsp at cycle 3: rsp_hit=0, rsp_way=0, no wb_valid; repeat read -> rsp_hit=1, rsp_way=0.
REQ-034 Writes to idx 0 tags 0xA0..0xA3, then read 0xA0, then write 0xB0 -> victim way 1 (largest age 3), wb_valid with wb_tag=0xA1, rsp_way=1.
REQ-035 With wb_ready held 0 for 5 cycles, wb_valid and wb_tag SHALL stay stable and req_ready=0; rsp_valid 2 cycles after wb_ready=1.
REQ-036 Invalidate a dirty hit -> writeback, then rsp_hit=1; a following read of the same tag -> rsp_hit=0, refills the freed way.
REQ-037 rst_n low during WB -> wb_valid drops asynchronously; after release, reading any prior tag -> rsp_hit=0.
REQ-038 Saturation: 20 hits to one way of a full set -> no other way's age exceeds 3; the next miss evicts the way with age 3.

Source files
------------

// File: rtl/l2_tag_ctrl.sv
// L2 tag controller: set-associative tag/valid/dirty/age store with an
// age-based LRU, one request at a time, and a dirty-victim writeback handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_op                  00 read, 01 write, 10 invalidate, 11 read
//   req_index/req_tag       lookup address
//   wb_valid/wb_ready       dirty-victim writeback handshake
//   wb_index/wb_tag         writeback line address
//   rsp_valid               one-cycle response pulse
//   rsp_hit/rsp_way         hit flag; way hit or way filled
module l2_tag_ctrl #(
    parameter  int WAYS    = 8,
    parameter  int INDEX_W = 6,
    parameter  int TAG_W   = 12,
    localparam int CNT_W   = $clog2(WAYS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [INDEX_W-1:0] wb_index,
    output logic [TAG_W-1:0]   wb_tag,
    output logic               rsp_valid,
    output logic               rsp_hit,
    output logic [CNT_W-1:0]   rsp_way
);

    localparam int SETS = 2**INDEX_W;
    localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(WAYS-1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, UPDATE, RESP} state_t;

    state_t state, state_nx;

    logic [WAYS-1:0]  vld  [SETS];
    logic [WAYS-1:0]  dty  [SETS];
    logic [TAG_W-1:0] tags [SETS][WAYS];
    logic [CNT_W-1:0] age  [SETS][WAYS];

    // Holds req_ready low until the first clock after reset release.
    logic up;

    logic [1:0]         op_q;
    logic [INDEX_W-1:0] idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic               hit_q;
    logic [CNT_W-1:0]   way_q;
    logic [INDEX_W-1:0] wbi_q;
    logic [TAG_W-1:0]   wbt_q;

    logic is_inv, is_wr;
    assign is_inv = (op_q == 2'b10);
    assign is_wr  = (op_q == 2'b01);

    logic [WAYS-1:0]  match;
    logic [CNT_W:0]   n_match;
    logic [CNT_W-1:0] hit_way, inv_way, lru_way, vic_way, sel_way;
    logic [CNT_W-1:0] lru_age, ref_age;
    logic             has_inv, hit_c, wb_c;

    always_comb begin
        match   = '0;
        n_match = '0;
        hit_way = '0;
        inv_way = '0;
        has_inv = 1'b0;
        lru_way = '0;
        lru_age = age[idx_q][0];
        // Descending scan so the lowest matching / invalid way wins.
        for (int w = WAYS-1; w >= 0; w--) begin
            match[w] = vld[idx_q][w] && (tags[idx_q][w] == tag_q);
            if (match[w]) hit_way = CNT_W'(w);
            if (!vld[idx_q][w]) begin
                has_inv = 1'b1;
                inv_way = CNT_W'(w);
            end
        end
        // Strict compare keeps the lowest index on an age tie.
        for (int w = 0; w < WAYS; w++) begin
            n_match = n_match + (CNT_W+1)'(match[w]);
            if (age[idx_q][w] > lru_age) begin
                lru_age = age[idx_q][w];
                lru_way = CNT_W'(w);
            end
        end
        hit_c   = (n_match == (CNT_W+1)'(1));
        vic_way = has_inv ? inv_way : lru_way;
        sel_way = hit_c ? hit_way : (is_inv ? '0 : vic_way);
        wb_c    = hit_c ? (is_inv && dty[idx_q][hit_way])
                        : (!is_inv && vld[idx_q][vic_way]
                                   && dty[idx_q][vic_way]);
    end

    // Age of the touched way before the update; an empty way counts as oldest.
    assign ref_age = vld[idx_q][way_q] ? age[idx_q][way_q] : AGE_MAX;

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        wb_valid  = 1'b0;
        rsp_valid = 1'b0;
        rsp_hit   = 1'b0;
        rsp_way   = '0;
        unique case (state)
            IDLE: begin
                req_ready = up;
                if (req_valid && up) state_nx = LOOKUP;
            end
            LOOKUP:  state_nx = wb_c ? WB : UPDATE;
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready) state_nx = UPDATE;
            end
            UPDATE:  state_nx = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_hit   = hit_q;
                rsp_way   = way_q;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign wb_index = wbi_q;
    assign wb_tag   = wbt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            up    <= 1'b0;
            op_q  <= '0;
            idx_q <= '0;
            tag_q <= '0;
            hit_q <= 1'b0;
            way_q <= '0;
            wbi_q <= '0;
            wbt_q <= '0;
        end else begin
            state <= state_nx;
            up    <= 1'b1;
            if (state == IDLE && req_valid && up) begin
                op_q  <= req_op;
                idx_q <= req_index;
                tag_q <= req_tag;
            end
            if (state == LOOKUP) begin
                hit_q <= hit_c;
                way_q <= sel_way;
                if (wb_c) begin
                    wbi_q <= idx_q;
                    wbt_q <= tags[idx_q][sel_way];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                vld[s] <= '0;
                dty[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= '0;
            end
        end else if (state == UPDATE) begin
            if (is_inv) begin
                if (hit_q) begin
                    vld[idx_q][way_q] <= 1'b0;
                    dty[idx_q][way_q] <= 1'b0;
                end
            end else begin
                for (int w = 0; w < WAYS; w++) begin
                    if (CNT_W'(w) == way_q)
                        age[idx_q][w] <= '0;
                    else if (vld[idx_q][w] && age[idx_q][w] < ref_age
                             && age[idx_q][w] != AGE_MAX)
                        age[idx_q][w] <= age[idx_q][w] + 1'b1;
                end
                vld[idx_q][way_q] <= 1'b1;
                if (!hit_q)
                    dty[idx_q][way_q] <= is_wr;
                else if (is_wr)
                    dty[idx_q][way_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == UPDATE && !is_inv && !hit_q)
            tags[idx_q][way_q] <= tag_q;
    end

endmodule

// File: tb/tb_l2_tag_ctrl.sv
// Scoreboard bench for l2_tag_ctrl (WAYS=4, INDEX_W=2, TAG_W=8):
// directed scenarios plus random traffic against a reference cache model.
module tb_l2_tag_ctrl;

    localparam int WAYS    = 4;
    localparam int INDEX_W = 2;
    localparam int TAG_W   = 8;
    localparam int SETS    = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [1:0]         req_op = '0;
    logic [INDEX_W-1:0] req_index = '0;
    logic [TAG_W-1:0]   req_tag = '0;
    logic               wb_valid;
    logic               wb_ready = 1'b0;
    logic [INDEX_W-1:0] wb_index;
    logic [TAG_W-1:0]   wb_tag;
    logic               rsp_valid;
    logic               rsp_hit;
    logic [1:0]         rsp_way;

    l2_tag_ctrl #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_index(req_index), .req_tag(req_tag),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_index(wb_index), .wb_tag(wb_tag),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        total++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference model: per-line valid/dirty/tag plus an age per line.
    int m_v [SETS][WAYS];
    int m_d [SETS][WAYS];
    int m_t [SETS][WAYS];
    int m_a [SETS][WAYS];

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_v[s][w] = 0; m_d[s][w] = 0; m_t[s][w] = 0; m_a[s][w] = 0;
            end
    endfunction

    function automatic void touch(input int s, input int w);
        int a_old;
        a_old = m_v[s][w] ? m_a[s][w] : WAYS - 1;
        for (int o = 0; o < WAYS; o++)
            if (o != w && m_v[s][o] != 0 && m_a[s][o] < a_old)
                m_a[s][o] = (m_a[s][o] + 1 > WAYS - 1) ? WAYS - 1 : m_a[s][o] + 1;
        m_a[s][w] = 0;
    endfunction

    task automatic model_access(input int op, input int s, input int tag,
                                output int hit, output int way,
                                output int wb, output int wbt);
        int n, hw, best;
        n = 0; hw = 0; wb = 0; wbt = 0; way = 0;
        for (int w = 0; w < WAYS; w++)
            if (m_v[s][w] != 0 && m_t[s][w] == tag) begin
                if (n == 0) hw = w;
                n++;
            end
        hit = (n == 1) ? 1 : 0;
        if (op == 2) begin
            if (hit != 0) begin
                way = hw;
                wb  = m_d[s][hw];
                wbt = m_t[s][hw];
                m_v[s][hw] = 0;
                m_d[s][hw] = 0;
            end
        end else if (hit != 0) begin
            way = hw;
            touch(s, hw);
            if (op == 1) m_d[s][hw] = 1;
        end else begin
            way = -1;
            for (int w = 0; w < WAYS; w++)
                if (way < 0 && m_v[s][w] == 0) way = w;
            if (way < 0) begin
                best = -1;
                for (int w = 0; w < WAYS; w++)
                    if (m_a[s][w] > best) begin best = m_a[s][w]; way = w; end
            end
            wb  = (m_v[s][way] != 0 && m_d[s][way] != 0) ? 1 : 0;
            wbt = m_t[s][way];
            touch(s, way);
            m_v[s][way] = 1;
            m_d[s][way] = (op == 1) ? 1 : 0;
            m_t[s][way] = tag;
        end
    endtask

    typedef struct { int hit; int way; int wb; int acc; } rsp_e;
    typedef struct { int idx; int tag; } wb_e;
    rsp_e rspq[$];
    wb_e  wbq[$];
    int   last_hs = 0;
    bit   busy = 1'b0;
    bit   busy_err = 1'b0;
    int   wb_mode = 2;

    initial forever begin
        @(posedge clk);
        #1;
        case (wb_mode)
            0:       wb_ready = 1'($urandom_range(0, 1));
            1:       wb_ready = 1'b0;
            default: wb_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        rsp_e e;
        if (!rst_n) begin
            busy = 1'b0;
        end else begin
            if (req_ready && busy) busy_err = 1'b1;
            if (req_valid && req_ready) busy = 1'b1;
            if (wb_valid) begin
                if (wbq.size() == 0) begin
                    chk("wb_unexpected", 32'(wb_valid), 0);
                end else begin
                    chk("wb_tag", 32'(wb_tag), wbq[0].tag);
                    chk("wb_index", 32'(wb_index), wbq[0].idx);
                    if (wb_ready) begin
                        void'(wbq.pop_front());
                        last_hs = cyc;
                    end
                end
            end
            if (rsp_valid) begin
                busy = 1'b0;
                if (rspq.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    e = rspq.pop_front();
                    chk("rsp_hit", 32'(rsp_hit), e.hit);
                    chk("rsp_way", 32'(rsp_way), e.way);
                    chk("rsp_latency", cyc, (e.wb != 0) ? last_hs + 2 : e.acc + 3);
                    chk("ready_held_off", 32'(busy_err), 0);
                    busy_err = 1'b0;
                end
            end
        end
    end

    task automatic issue(input int op, input int s, input int tag);
        int hit, way, wb, wbt, acc;
        bit ok;
        rsp_e e;
        wb_e  b;
        ok = 1'b0;
        acc = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = 2'(op);
        req_index = INDEX_W'(s);
        req_tag   = TAG_W'(tag);
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok  = 1'b1;
                acc = cyc;
            end
        end
        if (ok) begin
            model_access(op, s, tag, hit, way, wb, wbt);
            e.hit = hit; e.way = way; e.wb = wb; e.acc = acc;
            rspq.push_back(e);
            if (wb != 0) begin
                b.idx = s; b.tag = wbt;
                wbq.push_back(b);
            end
            @(posedge clk);
            #1;
        end else begin
            timeout_fail("issue_accept");
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (rspq.size() == 0 && !busy) return;
            @(negedge clk);
        end
        timeout_fail("drain");
        rspq.delete();
        wbq.delete();
    endtask

    task automatic wait_wb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (wb_valid) ok = 1'b1;
        end
        if (!ok) timeout_fail("wait_wb_valid");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_wb_valid"},  32'(wb_valid), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_hit"},   32'(rsp_hit), 0);
        chk({tag, "_rsp_way"},   32'(rsp_way), 0);
        chk({tag, "_wb_index"},  32'(wb_index), 0);
        chk({tag, "_wb_tag"},    32'(wb_tag), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;
        #1 chk("ready_before_clk", 32'(req_ready), 0);
        @(posedge clk);
        #1 chk("ready_first_clk", 32'(req_ready), 1);

        // Cold read, then a repeat read hits way 0.
        issue(0, 1, 'h11);
        issue(0, 1, 'h11);
        drain();

        // Fill set 0 dirty, touch way 0, then evict way 1 with wb_ready held low.
        for (int i = 0; i < 4; i++) issue(1, 0, 'hA0 + i);
        issue(0, 0, 'hA0);
        drain();
        wb_mode = 1;
        issue(1, 0, 'hB0);
        wait_wb(ok);
        if (ok) begin
            repeat (5) begin
                chk("wb_hold_valid", 32'(wb_valid), 1);
                chk("wb_hold_ready", 32'(req_ready), 0);
                @(negedge clk);
            end
        end
        wb_mode = 2;
        drain();

        // Invalidate a dirty hit, read it back, invalidate a miss.
        issue(2, 0, 'hA2);
        issue(0, 0, 'hA2);
        issue(2, 0, 'hEE);
        drain();

        // Saturation: 20 hits on one way of a full set, then a miss.
        for (int i = 0; i < 4; i++) issue(0, 2, 'h20 + i);
        repeat (20) issue(0, 2, 'h21);
        issue(0, 2, 'h30);
        drain();

        // Reset while a writeback is pending.
        wb_mode = 1;
        for (int i = 0; i < 5; i++) issue(1, 3, 'h50 + i);
        wait_wb(ok);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midwb");
        rspq.delete();
        wbq.delete();
        busy_err = 1'b0;
        model_clear();
        wb_mode = 2;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_midwb", 32'(req_ready), 1);
        issue(0, 3, 'h50);
        issue(0, 0, 'hA0);
        issue(0, 1, 'h11);
        issue(0, 3, 'h54);
        drain();

        // Random traffic over a small tag pool.
        wb_mode = 0;
        repeat (300)
            issue($urandom_range(0, 3), $urandom_range(0, 3),
                  'h40 + $urandom_range(0, 5));
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
